// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the integer pipeline. The unit keeps
// a shadow record {wr, ld, rd} for every instruction in flight between EX and
// the last writeback stage. For the instruction in ID it:
//   - raises a combinational stall when a source depends on a load whose data
//     is not yet in a forwardable pipeline register,
//   - registers EX operand-mux selects (nearest producer wins),
//   - counts cycles in which a stall bubble was inserted (saturating).
//
// Ports
//   clk          pipeline clock, rising edge
//   reset        asynchronous, active-high reset
//   id_valid     ID holds a real instruction
//   id_rs/id_rt  ID source registers A/B
//   id_rd        ID destination register
//   id_regwrite  ID instruction writes id_rd
//   id_memread   ID instruction is a load
//   freeze       global pipeline hold; all state holds
//   flush        squash the ID instruction (wins over stall)
//   stall        combinational; hold PC and IF/ID, inject bubble into EX
//   forward_rs   registered EX operand A source (0 = regfile, k = slot k-1)
//   forward_rt   registered EX operand B source
//   stall_count  saturating count of stall bubbles
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int FW         = $clog2(DEPTH + 1),
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              freeze,
  input  logic              flush,
  output logic              stall,
  output logic [FW-1:0]     forward_rs,
  output logic [FW-1:0]     forward_rt,
  output logic [CNT_W-1:0]  stall_count
);

  // The last writeback stage is never consulted (the register file writes
  // through for it), so only slots 0..DEPTH-2 carry state.
  localparam int NS = DEPTH - 1;

  logic              wr_r [NS];
  logic              ld_r [NS];
  logic [REG_AW-1:0] rd_r [NS];

  logic [FW-1:0]     sel_rs_s;
  logic [FW-1:0]     sel_rt_s;
  logic              haz_rs_s;
  logic              haz_rt_s;
  logic              stall_s;
  logic              bubble_s;

  // Nearest-producer search: scanning from the oldest tracked slot down to
  // slot 0 lets the youngest match overwrite older ones.
  always_comb begin
    sel_rs_s = {FW{1'b0}};
    sel_rt_s = {FW{1'b0}};
    haz_rs_s = 1'b0;
    haz_rt_s = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (wr_r[i] && (rd_r[i] == id_rs) && (id_rs != {REG_AW{1'b0}})) begin
        sel_rs_s = FW'(i + 1);
        haz_rs_s = ld_r[i] && ((i + 1) < LOAD_READY);
      end else begin
        sel_rs_s = sel_rs_s;
        haz_rs_s = haz_rs_s;
      end
      if (wr_r[i] && (rd_r[i] == id_rt) && (id_rt != {REG_AW{1'b0}})) begin
        sel_rt_s = FW'(i + 1);
        haz_rt_s = ld_r[i] && ((i + 1) < LOAD_READY);
      end else begin
        sel_rt_s = sel_rt_s;
        haz_rt_s = haz_rt_s;
      end
    end
  end

  // Stall and bubble decode; flush overrides a load-use stall.
  always_comb begin
    stall_s  = id_valid && !flush && (haz_rs_s || haz_rt_s);
    bubble_s = stall_s || flush || !id_valid;
  end

  assign stall = stall_s;

  // Slot pipeline: shift towards writeback on every non-frozen edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        wr_r[i] <= 1'b0;
        ld_r[i] <= 1'b0;
        rd_r[i] <= {REG_AW{1'b0}};
      end
    end else if (!freeze) begin
      for (int i = NS - 1; i > 0; i--) begin
        wr_r[i] <= wr_r[i-1];
        ld_r[i] <= ld_r[i-1];
        rd_r[i] <= rd_r[i-1];
      end
      wr_r[0] <= bubble_s ? 1'b0 : id_regwrite;
      ld_r[0] <= bubble_s ? 1'b0 : id_memread;
      rd_r[0] <= id_rd;
    end
  end

  // Forward selects follow the ID instruction into EX; bubbles select regfile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      forward_rs <= {FW{1'b0}};
      forward_rt <= {FW{1'b0}};
    end else if (!freeze) begin
      forward_rs <= bubble_s ? {FW{1'b0}} : sel_rs_s;
      forward_rt <= bubble_s ? {FW{1'b0}} : sel_rt_s;
    end
  end

  // Saturating stall-bubble counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (!freeze && stall_s && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0;
  logic       freeze = 1'b0, flush = 1'b0;

  // Instance A: defaults. Instance B: deeper pipe, late load data, tiny counter.
  logic        stall_a, stall_b;
  logic [1:0]  frs_a, frt_a;
  logic [2:0]  frs_b, frt_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  fwd_hazard_unit dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .freeze(freeze), .flush(flush), .stall(stall_a), .forward_rs(frs_a),
    .forward_rt(frt_a), .stall_count(cnt_a));

  fwd_hazard_unit #(.DEPTH(5), .LOAD_READY(3), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .freeze(freeze), .flush(flush), .stall(stall_b), .forward_rs(frs_b),
    .forward_rt(frt_b), .stall_count(cnt_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } rec_t;

  typedef struct {
    int st[2];
    int fr[2];
    int ft[2];
    int cnt[2];
  } exp_t;

  // Reference model: a log of what entered EX on each advancing edge, oldest
  // first. "Age k" = the instruction that entered EX k advances ago.
  rec_t log0[$];
  rec_t log1[$];
  int   m_fr[2], m_ft[2], m_cnt[2];
  int   m_depth[2] = '{3, 5};
  int   m_lr[2]    = '{2, 3};
  int   m_cmax[2]  = '{65535, 7};

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic rec_t rec_at(input int inst, input int age);
    rec_t r;
    r = '0;
    if (inst == 0) begin
      if (log0.size() - 1 - age >= 0) r = log0[log0.size() - 1 - age];
    end else begin
      if (log1.size() - 1 - age >= 0) r = log1[log1.size() - 1 - age];
    end
    return r;
  endfunction

  // Youngest instruction (age 0..DEPTH-2) writing src, or -1.
  function automatic int nearest(input int inst, input logic [4:0] src);
    rec_t r;
    if (src == 5'd0) return -1;
    for (int age = 0; age <= m_depth[inst] - 2; age++) begin
      r = rec_at(inst, age);
      if (r.wr && r.rd == src) return age;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  // One pipeline cycle of stimulus; computes and queues the expected response.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic rw, input logic mr,
                     input logic frz, input logic fl, input logic rst);
    exp_t e;
    int   kr, kt;
    bit   hr, ht, st, bub;
    rec_t nr;
    @(negedge clk);
    reset = rst; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_regwrite = rw; id_memread = mr; freeze = frz; flush = fl;
    if (rst) begin
      log0.delete(); log1.delete();
    end
    for (int inst = 0; inst < 2; inst++) begin
      if (rst) begin
        m_fr[inst] = 0; m_ft[inst] = 0; m_cnt[inst] = 0; st = 1'b0;
      end else begin
        kr = nearest(inst, rs);
        kt = nearest(inst, rt);
        hr = (kr >= 0) && rec_at(inst, kr).ld && (kr + 1 < m_lr[inst]);
        ht = (kt >= 0) && rec_at(inst, kt).ld && (kt + 1 < m_lr[inst]);
        st = v && !fl && (hr || ht);
        if (!frz) begin
          bub = st || fl || !v;
          nr.wr = bub ? 1'b0 : rw;
          nr.ld = bub ? 1'b0 : mr;
          nr.rd = rd;
          if (inst == 0) log0.push_back(nr); else log1.push_back(nr);
          m_fr[inst] = bub ? 0 : kr + 1;
          m_ft[inst] = bub ? 0 : kt + 1;
          if (st && m_cnt[inst] < m_cmax[inst]) m_cnt[inst]++;
        end
      end
      e.st[inst] = st; e.fr[inst] = m_fr[inst];
      e.ft[inst] = m_ft[inst]; e.cnt[inst] = m_cnt[inst];
    end
    exp_q.push_back(e);
  endtask

  task automatic nop();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    cyc(1'b1, rs, rt, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic load(input logic [4:0] rd);
    cyc(1'b1, 5'd0, 5'd0, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rst_cyc();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: stall sampled mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    int   sa, sb;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        sa = int'(stall_a);
        sb = int'(stall_b);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("stall_a", sa, e.st[0]);
        chk("stall_b", sb, e.st[1]);
        chk("fwd_rs_a", int'(frs_a), e.fr[0]);
        chk("fwd_rt_a", int'(frt_a), e.ft[0]);
        chk("fwd_rs_b", int'(frs_b), e.fr[1]);
        chk("fwd_rt_b", int'(frt_b), e.ft[1]);
        chk("count_a", int'(cnt_a), e.cnt[0]);
        chk("count_b", int'(cnt_b), e.cnt[1]);
      end
    end
  end

  initial begin
    rst_cyc(); rst_cyc(); nop();
    // Back-to-back ALU forward.
    alu(5'd0, 5'd0, 5'd3); alu(5'd3, 5'd1, 5'd4); nop(); nop();
    // Two producers of r5: nearest wins; then producer one further back.
    alu(5'd0, 5'd0, 5'd5); alu(5'd0, 5'd0, 5'd5); alu(5'd1, 5'd5, 5'd6); nop();
    alu(5'd0, 5'd0, 5'd5); nop(); alu(5'd5, 5'd1, 5'd6); nop(); nop();
    // Load-use on rt: stall one cycle, then forward 2.
    load(5'd7); alu(5'd1, 5'd7, 5'd8); alu(5'd1, 5'd7, 5'd8); nop(); nop();
    // r0 producer and non-writing producer.
    alu(5'd0, 5'd0, 5'd0); alu(5'd0, 5'd0, 5'd2);
    cyc(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); alu(5'd6, 5'd6, 5'd1); nop(); nop();
    // Freeze for 3 cycles during a load-use.
    load(5'd9);
    repeat (3) cyc(1'b1, 5'd9, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    alu(5'd9, 5'd0, 5'd1); alu(5'd9, 5'd0, 5'd1); nop(); nop();
    // Flush together with a load-use.
    load(5'd10); cyc(1'b1, 5'd10, 5'd10, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); nop(); nop();
    // Reset with slots full of r9 writers.
    repeat (4) alu(5'd0, 5'd0, 5'd9);
    rst_cyc(); alu(5'd9, 5'd9, 5'd1); nop(); nop(); nop(); nop();
    // Deep instance: load two ahead stalls, load three ahead forwards 3.
    load(5'd11); nop(); alu(5'd11, 5'd0, 5'd1); alu(5'd11, 5'd0, 5'd1); nop(); nop(); nop(); nop();
    load(5'd12); nop(); nop(); alu(5'd0, 5'd12, 5'd1); nop(); nop(); nop(); nop();
    // Repeated load-use to drive the small counter into saturation.
    for (int i = 0; i < 10; i++) begin
      load(5'd13); alu(5'd13, 5'd0, 5'd2); alu(5'd13, 5'd0, 5'd2);
    end
    // Randomized traffic over a small register set to provoke many matches.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 299) == 0));
    end
    nop();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the integer pipeline. It shadows the destination register of every in-flight instruction from EX through the final writeback stage in an internal slot pipeline. For the instruction in ID it computes the stall request, and it registers the EX-stage operand-mux selects so that the nearest producer always wins. It also provides freeze and flush controls and a stall-cycle counter for performance monitoring.

Parameters:
REG_AW, 5, register-address width.
DEPTH, 3, number of tracked stages after ID: slot 0 = EX, 1 = MEM, ..., DEPTH-1 = last writeback stage; legal range 2..8.
LOAD_READY, 2, first slot index whose pipeline register holds valid load data; legal range 1..DEPTH-1.
FW, $clog2(DEPTH+1), width of the forward selects.
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
id_valid  in  1  ID holds a real instruction.
id_rs  in  REG_AW  ID source register A.
id_rt  in  REG_AW  ID source register B.
id_rd  in  REG_AW  ID destination register.
id_regwrite  in  1  ID instruction writes id_rd.
id_memread  in  1  ID instruction is a load.
freeze  in  1  global pipeline hold (e.g. cache miss).
flush  in  1  squash the ID instruction (branch redirect).
stall  out  1  combinational; hold PC and IF/ID, inject a bubble into EX.
forward_rs  out  FW  registered; EX operand A source (0 = register file, k = slot k-1 pipeline register).
forward_rt  out  FW  registered; same for operand B.
stall_count  out  CNT_W  number of cycles in which stall caused a bubble.

Behaviour:
- Each slot holds {wr, ld, rd}.
- Reset (asynchronous): all slots wr=0 and ld=0; forward_rs = forward_rt = 0; stall_count = 0. Deasserting reset mid-operation restarts from this empty state; no stale match may occur.
- Match for a source s at slot i: slot[i].wr=1, slot[i].rd == s, and s != 0. Register 0 never matches and never stalls.
- Nearest producer is the lowest matching i over 0..DEPTH-2. Slot DEPTH-1 is written back during this cycle, and the register file handles that write-through.
- stall = id_valid & !flush & (for rs or rt, the nearest producer has ld=1 and i+1 < LOAD_READY). With the defaults, stall asserts only for a load in EX whose rd matches.
- Advance (when freeze=0): slot[i+1] <= slot[i] for i = 0..DEPTH-2; slot[DEPTH-1] is discarded.
- slot[0] loads a bubble (wr=0, ld=0) if stall, flush, or !id_valid. Otherwise it loads {id_regwrite, id_memread, id_rd}.
- Forward selects load on the same edge. The value is (nearest i)+1, or 0 if no match. Both selects load 0 when a bubble is inserted.
- freeze=1: slots, forward selects, and stall_count all hold. stall is still computed combinationally. flush is ignored while freeze=1; upstream holds flush until the pipeline unfreezes.
- flush and a stall condition together: flush wins. stall=0, a bubble is inserted, and the counter is not incremented.
- stall_count increments by 1 on each advancing edge with stall=1. It saturates at all-ones; there is no wrap.
- Latency: stall has 0 cycles of latency from the ID inputs. The forward selects are valid in the cycle after the ID instruction is accepted, i.e. while that instruction is in EX.
- A stalled instruction re-evaluates the following cycle against the advanced slots. With the defaults, the load is then in MEM, so forward = 2 and stall = 0.

Test Plan:
- Back-to-back ALU ops: a write to r3 followed by a read of r3 on rs -> forward_rs = 1 in the consumer's EX cycle; stall stays 0.
- Same register in two producers: r5 written in slot 1 and in slot 0 -> forward = 1, because the nearest producer wins. Producer only in slot 1 -> forward = 2.
- Load-use: a load writing r7 followed by a read of r7 on rt -> stall = 1 for exactly one cycle, a bubble enters EX, then forward_rt = 2 and stall_count goes from 0 to 1.
- Register 0 and id_regwrite=0: a producer with rd = 0, or with wr = 0, followed by a read of r0 or the same rd -> forward = 0, stall = 0.
- freeze and flush: freeze held for 3 cycles during a load-use -> slots, selects and count are unchanged and stall is held high. flush together with a load-use -> stall = 0, a bubble is inserted, and the count is unchanged.
- Reset mid-stream with slots full of r9 writers, then a read of r9 -> forward = 0 and stall_count = 0. Run with DEPTH = 5 and LOAD_READY = 3: a load two instructions ahead stalls, and a load three ahead forwards with the value 3.
